vcart_bank_ctrl: RTL and testbench
==================================

VCART_BANK_CTRL -- requirements
Module: vcart_bank_ctrl

Interface
REQ-001 SHALL have parameter: ROM_AW, 16, ROM byte-address width; supported ROM sizes are powers of two up to 2^ROM_AW bytes.
REQ-002 SHALL have port: clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-low reset; sampled on clk only.
REQ-004 SHALL have port: pho0_en  in  1  one-clk strobe per CPU cycle; bus fields valid when high.
REQ-005 SHALL have port: cpu_a  in  13  CPU address bus.
REQ-006 SHALL have port: cpu_rw  in  1  1=read, 0=write.
REQ-007 SHALL have port: cpu_d_in  in  8  CPU write data.
REQ-008 SHALL have port: cpu_d_out  out  8  cartridge read data to CPU.
REQ-009 SHALL have port: bs_type  in  4  scheme code: 0000=plain 2K/4K, 0001=F8, 0010=F6, 0110=F4, 0100=E0, 0101=3F; any other code is treated as 0000.
REQ-010 SHALL have port: sc  in  1  superchip RAM enable.
REQ-011 SHALL have port: rom_size  in  17  ROM image size in bytes.
REQ-012 SHALL have port: rom_a  out  ROM_AW  ROM byte address.
REQ-013 SHALL have port: rom_do  in  8  ROM data for rom_a.
REQ-014 SHALL have port: bank  out  5  current bank register (E0: slice-0 bank) for debug.

Function
REQ-015 SHALL define hotspot events as: cart access (cpu_a[12]=1), or for 3F only a write with cpu_a[12:6]=0, qualified by pho0_en=1; exactly one event per pho0_en strobe.
REQ-016 SHALL update bank registers on the clk edge where the event is sampled; rom_a SHALL be combinational from cpu_a and registers, so the hotspot access itself reads the old bank and the next access uses the new bank.
REQ-017 F8: $1FF8->bank 0, $1FF9->bank 1; rom_a = {bank[0], cpu_a[11:0]}.
REQ-018 F6: $1FF6..$1FF9->banks 0..3; rom_a = {bank[1:0], cpu_a[11:0]}.
REQ-019 F4: $1FF4..$1FFB->banks 0..7; rom_a = {bank[2:0], cpu_a[11:0]}.
REQ-020 E0: four 1K slices at cpu_a[11:10]; $1FE0-7 sets slice0, $1FE8-F slice1, $1FF0-7 slice2 to cpu_a[2:0]; slice3 is fixed at bank 7; rom_a = {slice_bank, cpu_a[9:0]}.
REQ-021 3F: write to $00-$3F loads bank3f <= cpu_d_in[4:0]; cpu_a[11]=0 -> rom_a = {bank3f, cpu_a[10:0]}; cpu_a[11]=1 -> {5'h1F, cpu_a[10:0]}.
REQ-022 Plain: rom_a = {0, cpu_a[11:0]}; no hotspots.
REQ-023 SHALL AND every raw rom_a with (rom_size-1) so small images mirror and 3F bank 5'h1F resolves to the last 2K bank; rom_size=0 SHALL give rom_a=0.
REQ-024 Superchip (sc=1, cpu_a[12]=1): $1000-$107F is write port; on pho0_en the internal 128x8 RAM[cpu_a[6:0]] <= cpu_d_in, regardless of cpu_rw; $1080-$10FF reads RAM[cpu_a[6:0]] combinationally onto cpu_d_out.
REQ-025 SHALL drive cpu_d_out = RAM data in superchip read window, else rom_do; superchip window accesses SHALL still decode hotspots (none overlap).
REQ-026 Hotspot address match SHALL use cpu_a[11:0] only, all mirrors within the cart space matching.
REQ-027 A change in bs_type SHALL reload all bank registers to their reset values on the next clk edge; a hotspot in that same cycle is ignored.
REQ-028 Repeated access to the same hotspot SHALL leave the bank unchanged; pho0_en=0 SHALL never change any register or the RAM.

Reset
REQ-029 While reset=0 at a clk edge: F8/F6/F4 bank <= highest bank (1/3/7); E0 slices <= 4,5,6; bank3f <= 0; bank output then shows the register for the current bs_type.
REQ-030 Superchip RAM contents SHALL NOT be cleared by reset; reset asserted mid-access SHALL override any same-cycle hotspot.

Verification
REQ-031 F8, reset release, read $1000 -> rom_a=$1000; read $1FF8 -> same cycle rom_a=$1FF8, next read $1000 -> rom_a=$0000.
REQ-032 F6, rom_size=16384, read $1FF7 then $1123 -> rom_a=$1123; then $3FF9 (mirror) -> bank=3, read $1000 -> rom_a=$3000.
REQ-033 E0, read $1FE9 then $1400 -> rom_a=$0400; read $1C05 -> rom_a=$1C05 (slice3 bank 7).
REQ-034 3F, rom_size=8192, write $3F data $02 -> read $1010 rom_a=$1010; read $1810 -> rom_a=$1810; data $07 -> masked to $1810 for $1010.
REQ-035 F8 sc=1: write $1005 data $A5 then read $1085 -> cpu_d_out=$A5; pho0_en held low during write -> RAM unchanged.
REQ-036 F4 bank 2 selected, change bs_type to F6 -> next cycle bank=3; assert reset same cycle as $1FF4 read -> bank=7.

Source files
------------

// File: rtl/vcart_bank_ctrl.sv
// vcart_bank_ctrl: cartridge bank switching (F8/F6/F4/E0/3F/plain) with optional 128-byte superchip RAM.
module vcart_bank_ctrl #(
   parameter int ROM_AW = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pho0_en,
   input  logic [12:0]       cpu_a,
   input  logic              cpu_rw,
   input  logic [7:0]        cpu_d_in,
   output logic [7:0]        cpu_d_out,
   input  logic [3:0]        bs_type,
   input  logic              sc,
   input  logic [16:0]       rom_size,
   output logic [ROM_AW-1:0] rom_a,
   input  logic [7:0]        rom_do,
   output logic [4:0]        bank
);
   logic       f8, f6, f4, e0, t3f;
   logic [3:0] prev_type;
   logic [2:0] bfx, s0, s1, s2, bfx_hi, slice_bank;
   logic [4:0] b3f;
   logic [16:0] raw;
   logic [7:0] ram [128];
   always_comb begin
      f8 = bs_type == 4'b0001;
      f6 = bs_type == 4'b0010;
      f4 = bs_type == 4'b0110;
      e0 = bs_type == 4'b0100;
      t3f = bs_type == 4'b0101;
      bfx_hi = f4 ? 3'd7 : f6 ? 3'd3 : f8 ? 3'd1 : 3'd0;
      slice_bank = cpu_a[11:10] == 2'd0 ? s0 : cpu_a[11:10] == 2'd1 ? s1 :
                   cpu_a[11:10] == 2'd2 ? s2 : 3'd7;
      raw = t3f ? (cpu_a[11] ? {1'b0, 5'h1F, cpu_a[10:0]} : {1'b0, b3f, cpu_a[10:0]}) :
            e0  ? {4'd0, slice_bank, cpu_a[9:0]} :
            f4  ? {2'd0, bfx, cpu_a[11:0]} :
            f6  ? {3'd0, bfx[1:0], cpu_a[11:0]} :
            f8  ? {4'd0, bfx[0], cpu_a[11:0]} : {5'd0, cpu_a[11:0]};
      rom_a = rom_size == 17'd0 ? '0 : ROM_AW'(raw & (rom_size - 17'd1));
      bank = (f8 || f6 || f4) ? {2'd0, bfx} : e0 ? {2'd0, s0} : t3f ? b3f : 5'd0;
      cpu_d_out = (sc && cpu_a[12] && cpu_a[11:7] == 5'd1) ? ram[cpu_a[6:0]] : rom_do;
   end
   // a scheme change reloads every bank register and swallows any same-cycle hotspot
   always_ff @(posedge clk) begin
      if (!reset || bs_type != prev_type) begin
         prev_type <= bs_type;
         bfx <= bfx_hi;
         s0 <= 3'd4;
         s1 <= 3'd5;
         s2 <= 3'd6;
         b3f <= 5'd0;
      end else if (pho0_en) begin
         if (cpu_a[12]) begin
            if (f8 && cpu_a[11:1] == 11'h7FC) bfx <= {2'd0, cpu_a[0]};
            if (f6 && cpu_a[11:0] >= 12'hFF6 && cpu_a[11:0] <= 12'hFF9) bfx <= cpu_a[2:0] - 3'd6;
            if (f4 && cpu_a[11:0] >= 12'hFF4 && cpu_a[11:0] <= 12'hFFB) bfx <= cpu_a[2:0] - 3'd4;
            if (e0 && cpu_a[11:5] == 7'h7F && cpu_a[4:3] == 2'd0) s0 <= cpu_a[2:0];
            if (e0 && cpu_a[11:5] == 7'h7F && cpu_a[4:3] == 2'd1) s1 <= cpu_a[2:0];
            if (e0 && cpu_a[11:5] == 7'h7F && cpu_a[4:3] == 2'd2) s2 <= cpu_a[2:0];
         end
         if (t3f && !cpu_rw && cpu_a[12:6] == 7'd0) b3f <= cpu_d_in[4:0];
      end
   end
   // superchip RAM is never cleared; the write port ignores cpu_rw
   always_ff @(posedge clk)
      if (pho0_en && sc && cpu_a[12] && cpu_a[11:7] == 5'd0) ram[cpu_a[6:0]] <= cpu_d_in;
endmodule

// File: tb/tb_vcart_bank_ctrl.sv
// tb_vcart_bank_ctrl: directed vectors with hand-computed expectations for vcart_bank_ctrl.
module tb_vcart_bank_ctrl;
   logic        clk = 1'b0;
   logic        reset, pho0_en, cpu_rw, sc;
   logic [12:0] cpu_a;
   logic [7:0]  cpu_d_in, cpu_d_out;
   logic [7:0]  rom_do = 8'h3C;
   logic [3:0]  bs_type;
   logic [16:0] rom_size;
   logic [15:0] rom_a;
   logic [4:0]  bank;
   int vectors = 0, miscompares = 0;

   vcart_bank_ctrl #(.ROM_AW(16)) dut (
      .clk(clk), .reset(reset), .pho0_en(pho0_en), .cpu_a(cpu_a), .cpu_rw(cpu_rw),
      .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out), .bs_type(bs_type), .sc(sc),
      .rom_size(rom_size), .rom_a(rom_a), .rom_do(rom_do), .bank(bank)
   );

   always #5 clk = ~clk;

   // drive one bus cycle just after a falling edge; the next rising edge samples it
   task automatic step(input logic [12:0] a, input logic rw, input logic [7:0] d, input logic en);
      @(negedge clk);
      cpu_a = a;
      cpu_rw = rw;
      cpu_d_in = d;
      pho0_en = en;
      #1;
   endtask

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; pho0_en = 1'b0; cpu_a = '0; cpu_rw = 1'b1; cpu_d_in = '0;
      bs_type = 4'b0001; sc = 1'b0; rom_size = 17'h10000;
      // F8
      step(13'h0000, 1, 8'h00, 0);
      chk("f8_reset_bank", bank, 17'd1);
      reset = 1'b1;
      step(13'h1000, 1, 8'h00, 1);
      chk("f8_rd1000", rom_a, 17'h1000);
      chk("rom_data_out", cpu_d_out, 17'h3C);
      step(13'h1FF8, 1, 8'h00, 1);
      chk("f8_hot_oldbank", rom_a, 17'h1FF8);
      step(13'h1000, 1, 8'h00, 1);
      chk("f8_bank0_rd", rom_a, 17'h0000);
      chk("f8_bank0", bank, 17'd0);
      step(13'h1FF9, 1, 8'h00, 1);
      chk("f8_hot9_old", rom_a, 17'h0FF9);
      step(13'h1FF9, 1, 8'h00, 1);
      chk("f8_hot9_repeat", rom_a, 17'h1FF9);
      step(13'h1000, 1, 8'h00, 1);
      chk("f8_bank1_rd", rom_a, 17'h1000);
      step(13'h1FF8, 1, 8'h00, 0);
      step(13'h1000, 1, 8'h00, 1);
      chk("f8_no_strobe", bank, 17'd1);
      // hotspot during a scheme change is ignored
      step(13'h1FF8, 1, 8'h00, 1);
      bs_type = 4'b0010;
      step(13'h1000, 1, 8'h00, 1);
      chk("chg_ignores_hot", bank, 17'd3);
      chk("f6_bank3_rd", rom_a, 17'h3000);
      // F4 then change to F6
      step(13'h0000, 1, 8'h00, 0);
      bs_type = 4'b0110;
      step(13'h0000, 1, 8'h00, 0);
      chk("f4_reload", bank, 17'd7);
      step(13'h1FF6, 1, 8'h00, 1);
      chk("f4_hot_oldbank", rom_a, 17'h7FF6);
      step(13'h1000, 1, 8'h00, 1);
      chk("f4_bank2_rd", rom_a, 17'h2000);
      chk("f4_bank2", bank, 17'd2);
      step(13'h0000, 1, 8'h00, 0);
      bs_type = 4'b0010;
      step(13'h0000, 1, 8'h00, 0);
      chk("f4_to_f6", bank, 17'd3);
      // reset overrides a same-cycle hotspot
      bs_type = 4'b0110;
      step(13'h0000, 1, 8'h00, 0);
      step(13'h1FF6, 1, 8'h00, 1);
      step(13'h1FF4, 1, 8'h00, 1);
      chk("f4_bank2_again", bank, 17'd2);
      reset = 1'b0;
      step(13'h0000, 1, 8'h00, 0);
      reset = 1'b1;
      chk("rst_over_hot", bank, 17'd7);
      // F6 with 16K image
      step(13'h0000, 1, 8'h00, 0);
      bs_type = 4'b0010;
      rom_size = 17'h4000;
      step(13'h0000, 1, 8'h00, 0);
      chk("f6_reset_bank", bank, 17'd3);
      step(13'h1FF7, 1, 8'h00, 1);
      chk("f6_hot7_old", rom_a, 17'h3FF7);
      step(13'h1123, 1, 8'h00, 1);
      chk("f6_bank1_rd", rom_a, 17'h1123);
      step(13'h1FF9, 1, 8'h00, 1);
      chk("f6_hot9_old", rom_a, 17'h1FF9);
      step(13'h1000, 1, 8'h00, 1);
      chk("f6_bank3_rd2", rom_a, 17'h3000);
      chk("f6_bank3", bank, 17'd3);
      rom_size = 17'h1000;
      #1 chk("mirror_4k", rom_a, 17'h0000);
      rom_size = 17'h00000;
      #1 chk("size_zero", rom_a, 17'h0000);
      rom_size = 17'h10000;
      // E0
      step(13'h0000, 1, 8'h00, 0);
      bs_type = 4'b0100;
      step(13'h0000, 1, 8'h00, 0);
      chk("e0_reset_bank", bank, 17'd4);
      step(13'h1FE9, 1, 8'h00, 1);
      step(13'h1400, 1, 8'h00, 1);
      chk("e0_slice1", rom_a, 17'h0400);
      step(13'h1C05, 1, 8'h00, 1);
      chk("e0_slice3", rom_a, 17'h1C05);
      step(13'h1000, 1, 8'h00, 1);
      chk("e0_slice0_rst", rom_a, 17'h1000);
      step(13'h1FE2, 1, 8'h00, 1);
      step(13'h1000, 1, 8'h00, 1);
      chk("e0_slice0", rom_a, 17'h0800);
      chk("e0_bank_out", bank, 17'd2);
      step(13'h1FF3, 1, 8'h00, 1);
      step(13'h1800, 1, 8'h00, 1);
      chk("e0_slice2", rom_a, 17'h0C00);
      step(13'h1FFA, 1, 8'h00, 1);
      step(13'h1800, 1, 8'h00, 1);
      chk("e0_no_slice3_hot", rom_a, 17'h0C00);
      // 3F with 8K image
      step(13'h0000, 1, 8'h00, 0);
      bs_type = 4'b0101;
      rom_size = 17'h2000;
      step(13'h0000, 1, 8'h00, 0);
      chk("3f_reset_bank", bank, 17'd0);
      step(13'h003F, 0, 8'h02, 1);
      step(13'h1010, 1, 8'h00, 1);
      chk("3f_bank2_rd", rom_a, 17'h1010);
      chk("3f_bank2", bank, 17'd2);
      step(13'h1810, 1, 8'h00, 1);
      chk("3f_last_bank", rom_a, 17'h1810);
      step(13'h0000, 0, 8'h07, 1);
      step(13'h1010, 1, 8'h00, 1);
      chk("3f_masked", rom_a, 17'h1810);
      step(13'h0040, 0, 8'h01, 1);
      step(13'h003F, 1, 8'h00, 1);
      step(13'h1010, 1, 8'h00, 1);
      chk("3f_no_hot", bank, 17'd7);
      // plain and unknown codes
      step(13'h0000, 1, 8'h00, 0);
      bs_type = 4'b0000;
      rom_size = 17'h1000;
      step(13'h1FF8, 1, 8'h00, 1);
      chk("plain_rd", rom_a, 17'h0FF8);
      step(13'h1000, 1, 8'h00, 1);
      chk("plain_bank", bank, 17'd0);
      bs_type = 4'b1111;
      step(13'h1FF8, 1, 8'h00, 1);
      chk("unknown_rd", rom_a, 17'h0FF8);
      chk("unknown_bank", bank, 17'd0);
      // superchip on F8
      step(13'h0000, 1, 8'h00, 0);
      bs_type = 4'b0001;
      sc = 1'b1;
      rom_size = 17'h10000;
      step(13'h1005, 0, 8'hA5, 1);
      step(13'h1085, 1, 8'h00, 1);
      chk("sc_rd_a5", cpu_d_out, 17'hA5);
      step(13'h1006, 1, 8'h5A, 1);
      step(13'h1086, 1, 8'h00, 1);
      chk("sc_wr_on_read", cpu_d_out, 17'h5A);
      step(13'h1005, 0, 8'hFF, 0);
      step(13'h1085, 1, 8'h00, 1);
      chk("sc_no_strobe", cpu_d_out, 17'hA5);
      step(13'h1185, 1, 8'h00, 1);
      chk("sc_outside", cpu_d_out, 17'h3C);
      step(13'h1085, 1, 8'h00, 1);
      sc = 1'b0;
      #1 chk("sc_off", cpu_d_out, 17'h3C);
      sc = 1'b1;
      step(13'h0000, 1, 8'h00, 0);
      reset = 1'b0;
      step(13'h0000, 1, 8'h00, 0);
      reset = 1'b1;
      step(13'h1085, 1, 8'h00, 1);
      chk("sc_survives_rst", cpu_d_out, 17'hA5);
      chk("sc_rst_bank", bank, 17'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
